// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx -- I2S master transmitter.
//
// Accepts a stereo sample pair through a valid/ready handshake into a
// one-deep holding register and serialises it onto an I2S DAC interface.
// MCLK, BCK and LRCK are all divided down from clk. A frame is 64 BCK
// periods: 32 slots per channel, left first. Each channel is sent MSB first
// with the standard one-BCK I2S delay.
//
// Optional build macro:
//   I2S_TX_ZERO_FILL_EN  when defined, an underflow sends silence (and
//                        forgets the last pair). When undefined, the last
//                        accepted pair is repeated.
//
// Ports:
//   clk           system clock (clk_pixel domain)
//   rst_n         asynchronous active-low reset. The upstream reset
//                 generator releases it synchronously to clk.
//   sample_l/r    left/right sample, two's complement, SAMPLE_WIDTH bits
//   sample_valid  sample pair offered
//   sample_ready  holding register empty. A transfer happens on a clk edge
//                 when valid and ready are both high.
//   i2s_mclk      master clock, clk / (2*MCLK_HALF)
//   i2s_bck       bit clock, MCLK / BCK_RATIO
//   i2s_lrck      word select (0 = left, 1 = right), changes on BCK fall
//   i2s_dout      serial data, changes on BCK fall
//   frame_start   one-clk pulse on the clk that performs a frame boundary
//   underflow     one-clk pulse when that boundary finds the holder empty
// ---------------------------------------------------------------------------
module i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,  // bits per channel, at most 31
    parameter int MCLK_HALF    = 3,   // clk cycles per MCLK half-period
    parameter int BCK_RATIO    = 4    // MCLK periods per BCK period, even, >= 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    i2s_mclk,
    output logic                    i2s_bck,
    output logic                    i2s_lrck,
    output logic                    i2s_dout,
    output logic                    frame_start,
    output logic                    underflow
);

    localparam int MCLK_CNT_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
    localparam int BCK_HALF   = BCK_RATIO / 2;
    localparam int BCK_CNT_W  = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

    localparam logic [MCLK_CNT_W-1:0] MCLK_LAST = MCLK_CNT_W'(MCLK_HALF - 1);
    localparam logic [BCK_CNT_W-1:0]  BCK_LAST  = BCK_CNT_W'(BCK_HALF - 1);
    localparam logic [4:0]            BIT_LAST  = 5'(SAMPLE_WIDTH);

    logic [MCLK_CNT_W-1:0]   mclk_cnt;
    logic [BCK_CNT_W-1:0]    bck_cnt;
    logic [5:0]              slot;       // k: BCK slot within the frame
    logic [SAMPLE_WIDTH-1:0] shift_l;
    logic [SAMPLE_WIDTH-1:0] shift_r;
    logic [SAMPLE_WIDTH-1:0] last_l;
    logic [SAMPLE_WIDTH-1:0] last_r;
    logic [SAMPLE_WIDTH-1:0] hold_l;
    logic [SAMPLE_WIDTH-1:0] hold_r;
    logic [SAMPLE_WIDTH-1:0] load_l;
    logic [SAMPLE_WIDTH-1:0] load_r;

    logic       mclk_wrap;
    logic       mclk_rise;
    logic       bck_toggle;
    logic       bck_fall;
    logic       boundary;
    logic       accept;
    logic [5:0] slot_nxt;
    logic [4:0] bit_idx;
    logic       bit_active;
    logic       dout_nxt;
    logic       shift_en_l;
    logic       shift_en_r;

    // Clock-divider strobes, all decoded from registered state so that each
    // is high for exactly the clk whose closing edge performs the event.
    assign mclk_wrap  = (mclk_cnt == MCLK_LAST);
    assign mclk_rise  = mclk_wrap && !i2s_mclk;
    assign bck_toggle = mclk_rise && (bck_cnt == BCK_LAST);
    assign bck_fall   = bck_toggle && i2s_bck;

    // Everything driven on a BCK fall reflects the slot being entered.
    assign slot_nxt   = slot + 6'd1;
    assign bit_idx    = slot_nxt[4:0];
    assign bit_active = (bit_idx != 5'd0) && (bit_idx <= BIT_LAST);
    assign dout_nxt   = bit_active &&
                        (slot_nxt[5] ? shift_r[SAMPLE_WIDTH-1] : shift_l[SAMPLE_WIDTH-1]);
    assign shift_en_l = bck_fall && bit_active && !slot_nxt[5];
    assign shift_en_r = bck_fall && bit_active &&  slot_nxt[5];

    assign boundary     = bck_fall && (slot == 6'd63);
    assign accept       = sample_valid && sample_ready;
    assign frame_start  = boundary;
    assign underflow    = boundary && sample_ready;

    // Pair loaded at a boundary: the holder if full, otherwise the underflow
    // fill. The last-pair register takes the same value, which leaves it
    // unchanged on a repeat and clears it on a zero fill.
    // NOTE: every always_comb output is assigned a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
`ifdef I2S_TX_ZERO_FILL_EN
        load_l = '0;
        load_r = '0;
`else
        load_l = last_l;
        load_r = last_r;
`endif
        if (!sample_ready) begin
            load_l = hold_l;
            load_r = hold_r;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mclk_cnt     <= '0;
            i2s_mclk     <= 1'b0;
            bck_cnt      <= '0;
            i2s_bck      <= 1'b0;
            slot         <= 6'd63;  // first BCK fall is a frame boundary
            i2s_lrck     <= 1'b0;
            i2s_dout     <= 1'b0;
            shift_l      <= '0;
            shift_r      <= '0;
            last_l       <= '0;
            last_r       <= '0;
            sample_ready <= 1'b1;
        end else begin
            mclk_cnt <= mclk_wrap ? '0 : mclk_cnt + 1'b1;
            if (mclk_wrap) begin
                i2s_mclk <= !i2s_mclk;
            end
            if (mclk_rise) begin
                bck_cnt <= (bck_cnt == BCK_LAST) ? '0 : bck_cnt + 1'b1;
            end
            if (bck_toggle) begin
                i2s_bck <= !i2s_bck;
            end

            if (bck_fall) begin
                slot     <= slot_nxt;
                i2s_lrck <= slot_nxt[5];
                i2s_dout <= dout_nxt;
            end

            // A boundary always enters slot 0, a padding bit, so loading
            // never coincides with a shift.
            if (boundary) begin
                shift_l <= load_l;
                shift_r <= load_r;
                last_l  <= load_l;
                last_r  <= load_r;
            end else begin
                if (shift_en_l) shift_l <= shift_l << 1;
                if (shift_en_r) shift_r <= shift_r << 1;
            end

            // sample_ready is the holder-empty flag. Accept needs ready high
            // and a full-holder boundary needs it low, so both never apply.
            if (boundary && !sample_ready) begin
                sample_ready <= 1'b1;
            end else if (accept) begin
                sample_ready <= 1'b0;
            end
        end
    end

    // NOTE: the holder data has no reset; sample_ready marks it empty after
    // reset, so its contents are never used before the first accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_l <= sample_l;
            hold_r <= sample_r;
        end
    end

endmodule
